// File: rtl/ex_div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer for the EX stage.
// Accepts DIV/DIVU/REM/REMU, runs a 32-step restoring division on operand
// magnitudes, applies the sign fix-up, and presents the result for exactly
// one cycle while holding the pipeline with STALL until then.
module ex_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       FUNC3,
  input  logic [WIDTH-1:0] OPERAND_A,
  input  logic [WIDTH-1:0] OPERAND_B,
  input  logic             FLUSH,
  output logic             STALL,
  output logic             BUSY,
  output logic [WIDTH-1:0] RESULT,
  output logic             RESULT_VALID
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;

  // Datapath registers (operands, partial remainder, quotient, sign flags)
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo;
  logic             is_rem_q;
  logic             neg_q;
  logic             neg_r;

  // Operand decode at the accept point
  logic             is_signed, is_rem, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             accept, div_zero, overflow, fast;
  logic [WIDTH-1:0] fast_result;

  // One restoring-division step and the sign-corrected final value
  logic [WIDTH:0]   r_shift, trial;
  logic [WIDTH-1:0] r_step, q_step;
  logic [WIDTH-1:0] final_result;
  logic             last;

  // DIV/DIVU vs REM/REMU is FUNC3[1]; signedness is FUNC3[0]; FUNC3[2] is
  // always set for the M-extension divides and carries no information here.
  logic unused_func3;
  assign unused_func3 = FUNC3[2];

  assign is_signed   = ~FUNC3[0];
  assign is_rem      = FUNC3[1];
  assign a_neg       = is_signed & OPERAND_A[WIDTH-1];
  assign b_neg       = is_signed & OPERAND_B[WIDTH-1];
  assign a_abs       = a_neg ? -OPERAND_A : OPERAND_A;
  assign b_abs       = b_neg ? -OPERAND_B : OPERAND_B;
  assign accept      = (state == IDLE) & START & ~FLUSH;
  assign div_zero    = (OPERAND_B == '0);
  assign overflow    = is_signed & (OPERAND_A == MIN_INT) & (OPERAND_B == '1);
  assign fast        = div_zero | overflow;
  // Divide-by-zero returns the raw dividend as remainder; signed overflow
  // returns MIN_INT as quotient and zero remainder.
  assign fast_result = div_zero ? (is_rem ? OPERAND_A : '1)
                                : (is_rem ? '0 : MIN_INT);

  assign last    = (cnt == CW'(WIDTH - 1));
  assign r_shift = {rem_q, quo[WIDTH-1]};
  assign trial   = r_shift - {1'b0, divisor};
  // The partial remainder stays below the divisor, so it always fits in
  // WIDTH bits; trial[WIDTH] is the borrow that says "did not fit".
  assign r_step  = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_step  = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign final_result = is_rem_q ? (neg_r ? -r_step : r_step)
                                 : (neg_q ? -q_step : q_step);

  // Next-state selection and the combinational pipeline stall
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_next = state;
    STALL      = 1'b0;
    case (state)
      IDLE: if (accept) state_next = fast ? DONE : RUN;
      RUN:  if (last)   state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (FLUSH) state_next = IDLE;
    STALL = ~RST & ~FLUSH & (((state == IDLE) & START) | (state == RUN));
  end

  // Control state, iteration counter and registered outputs
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state        <= IDLE;
      cnt          <= '0;
      BUSY         <= 1'b0;
      RESULT_VALID <= 1'b0;
      RESULT       <= '0;
    end else begin
      state        <= state_next;
      cnt          <= ((state == RUN) && (state_next == RUN)) ? cnt + CW'(1) : '0;
      BUSY         <= (state_next != IDLE);
      RESULT_VALID <= (state_next == DONE);
      if (state_next == DONE) begin
        RESULT <= (state == IDLE) ? fast_result : final_result;
      end
    end
  end

  // Operand capture on accept and one shift/subtract step per RUN cycle
  always_ff @(posedge CLK) begin
    // NOTE: datapath registers carry no reset; they are always loaded on accept before being read.
    if (accept) begin
      divisor  <= b_abs;
      quo      <= a_abs;
      rem_q    <= '0;
      is_rem_q <= is_rem;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
    end else if (state == RUN) begin
      quo   <= q_step;
      rem_q <= r_step;
    end
  end

endmodule
